// File: rtl/write_side_pointer_sync.sv
// Write-domain receiver for the async FIFO read pointer: gray synchroniser,
// gray-to-binary, occupancy/full/almost-full and a sticky invariant error.
module write_side_pointer_sync #(
    parameter int unsigned ADDRESS_SIZE       = 4,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
    input  logic                    write_clk,
    input  logic                    write_reset,
    input  logic [ADDRESS_SIZE:0]   read_pointer,
    input  logic [ADDRESS_SIZE:0]   write_pointer_bin,
    input  logic                    error_clear,
    output logic [ADDRESS_SIZE:0]   synchronized_read_pointer,
    output logic [ADDRESS_SIZE:0]   synchronized_read_pointer_bin,
    output logic [ADDRESS_SIZE:0]   used_count,
    output logic                    full,
    output logic                    almost_full,
    output logic                    pointer_error,
    output logic                    sync_valid
);

    localparam int unsigned PTR_W    = ADDRESS_SIZE + 1;
    localparam int unsigned DEPTH    = 1 << ADDRESS_SIZE;
    localparam int unsigned CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_THR   = PTR_W'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SYNC_STAGES + 1);

    logic [PTR_W-1:0] stage_q [SYNC_STAGES];
    logic [PTR_W-1:0] stage_d [SYNC_STAGES];
    logic [PTR_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pointer_error_q, pointer_error_d;
    logic             sync_valid_q, sync_valid_d;
    logic             violation;

    // Plain shift chain; only stage 0 sees the asynchronous input.
    always_comb begin
        stage_d[0] = read_pointer;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Binary bit j is the XOR of all gray bits at or above j.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            bin_d = bin_d ^ (stage_q[SYNC_STAGES-1] >> i);
        end
    end

    assign used_count  = write_pointer_bin - bin_q;
    assign full        = (used_count >= DEPTH_P);
    assign almost_full = (used_count >= AF_THR);
    assign violation   = (used_count > DEPTH_P);

    // Sticky error: a fresh violation overrides a simultaneous clear.
    always_comb begin
        pointer_error_d = pointer_error_q;
        if (violation) begin
            pointer_error_d = 1'b1;
        end else if (error_clear) begin
            pointer_error_d = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end
        sync_valid_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= '0;
            end
            bin_q           <= '0;
            count_q         <= '0;
            pointer_error_q <= 1'b0;
            sync_valid_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_d[i];
            end
            bin_q           <= bin_d;
            count_q         <= count_d;
            pointer_error_q <= pointer_error_d;
            sync_valid_q    <= sync_valid_d;
        end
    end

    assign synchronized_read_pointer     = stage_q[SYNC_STAGES-1];
    assign synchronized_read_pointer_bin = bin_q;
    assign pointer_error                 = pointer_error_q;
    assign sync_valid                    = sync_valid_q;

endmodule

// File: tb/tb_write_side_pointer_sync.sv
// Directed bench for write_side_pointer_sync: one 2-stage instance for the
// datapath scenarios and a 3-stage instance for the sync_valid timing.
module tb_write_side_pointer_sync;

    logic       clk;
    logic       rst;
    logic       rst3;
    logic [4:0] rp;
    logic [4:0] wp;
    logic       clr;

    logic [4:0] srp, srp_bin, used;
    logic       full, af, perr, sv;
    logic [4:0] srp3, srp_bin3, used3;
    logic       full3, af3, perr3, sv3;

    int checks;
    int failures;

    write_side_pointer_sync #(
        .ADDRESS_SIZE(4), .SYNC_STAGES(2), .ALMOST_FULL_MARGIN(2)
    ) dut (
        .write_clk(clk), .write_reset(rst), .read_pointer(rp),
        .write_pointer_bin(wp), .error_clear(clr),
        .synchronized_read_pointer(srp), .synchronized_read_pointer_bin(srp_bin),
        .used_count(used), .full(full), .almost_full(af),
        .pointer_error(perr), .sync_valid(sv)
    );

    write_side_pointer_sync #(
        .ADDRESS_SIZE(4), .SYNC_STAGES(3), .ALMOST_FULL_MARGIN(2)
    ) dut3 (
        .write_clk(clk), .write_reset(rst3), .read_pointer(rp),
        .write_pointer_bin(wp), .error_clear(clr),
        .synchronized_read_pointer(srp3), .synchronized_read_pointer_bin(srp_bin3),
        .used_count(used3), .full(full3), .almost_full(af3),
        .pointer_error(perr3), .sync_valid(sv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1; rp = 5'd0; wp = 5'd0; clr = 1'b0;
        tick(2);
        checks++;
        if (srp !== 5'd0 || srp_bin !== 5'd0 || perr !== 1'b0 || sv !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got srp=%0d bin=%0d perr=%0b sv=%0b required all 0",
                     srp, srp_bin, perr, sv);
        end
        checks++;
        if (used !== 5'd0 || full !== 1'b0 || af !== 1'b0) begin
            failures++;
            $display("FAIL reset_used got used=%0d full=%0b af=%0b required 0/0/0", used, full, af);
        end
        rst = 1'b0;
        rp = 5'b10001;
        tick(5);
        checks++;
        if (srp !== 5'b10001 || srp_bin !== 5'd30 || sv !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_stream got srp=%b bin=%0d sv=%0b required 10001/30/1",
                     srp, srp_bin, sv);
        end
        wp = 5'd7;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (srp !== 5'd0 || srp_bin !== 5'd0 || perr !== 1'b0 || sv !== 1'b0) begin
            failures++;
            $display("FAIL midstream_reset got srp=%0d bin=%0d perr=%0b sv=%0b required all 0",
                     srp, srp_bin, perr, sv);
        end
        checks++;
        if (used !== 5'd7 || full !== 1'b0) begin
            failures++;
            $display("FAIL midstream_reset_used got used=%0d full=%0b required 7/0", used, full);
        end
        rp = 5'd0;
        wp = 5'd1;
        #1 rst = 1'b0;
        tick(1);
        checks++;
        if (srp !== 5'd0 || used !== 5'd1) begin
            failures++;
            $display("FAIL post_reset_hold got srp=%0d used=%0d required 0/1", srp, used);
        end
    endtask

    task automatic test_latency();
        rp = 5'b00001;
        tick(1);
        checks++;
        if (srp !== 5'd0) begin
            failures++;
            $display("FAIL latency_edge_k got srp=%b required 00000", srp);
        end
        tick(1);
        checks++;
        if (srp !== 5'b00001 || srp_bin !== 5'd0) begin
            failures++;
            $display("FAIL latency_edge_k1 got srp=%b bin=%0d required 00001/0", srp, srp_bin);
        end
        tick(1);
        checks++;
        if (srp_bin !== 5'd1 || used !== 5'd0) begin
            failures++;
            $display("FAIL latency_edge_k2 got bin=%0d used=%0d required 1/0", srp_bin, used);
        end
    endtask

    task automatic test_full();
        rp = 5'd0;
        tick(4);
        wp = 5'd13;
        #1;
        checks++;
        if (used !== 5'd13 || af !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_13 got used=%0d af=%0b full=%0b required 13/0/0", used, af, full);
        end
        wp = 5'd14;
        #1;
        checks++;
        if (used !== 5'd14 || af !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_14 got used=%0d af=%0b full=%0b required 14/1/0", used, af, full);
        end
        wp = 5'd16;
        #1;
        checks++;
        if (used !== 5'd16 || af !== 1'b1 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_16 got used=%0d af=%0b full=%0b required 16/1/1", used, af, full);
        end
        tick(1);
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL full_no_error got perr=%0b required 0", perr);
        end
    endtask

    task automatic test_wrap();
        wp = 5'd3;
        rp = 5'b10001;
        tick(4);
        checks++;
        if (srp_bin !== 5'd30 || used !== 5'd5 || full !== 1'b0 || af !== 1'b0) begin
            failures++;
            $display("FAIL wrap got bin=%0d used=%0d full=%0b af=%0b required 30/5/0/0",
                     srp_bin, used, full, af);
        end
        tick(1);
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL wrap_no_error got perr=%0b required 0", perr);
        end
    endtask

    task automatic test_error();
        wp = 5'd6;
        rp = 5'b00110;
        tick(4);
        checks++;
        if (srp_bin !== 5'd4 || used !== 5'd2 || perr !== 1'b0) begin
            failures++;
            $display("FAIL err_setup got bin=%0d used=%0d perr=%0b required 4/2/0",
                     srp_bin, used, perr);
        end
        wp = 5'd2;
        #1;
        checks++;
        if (used !== 5'd30 || perr !== 1'b0) begin
            failures++;
            $display("FAIL err_before_edge got used=%0d perr=%0b required 30/0", used, perr);
        end
        tick(1);
        checks++;
        if (perr !== 1'b1) begin
            failures++;
            $display("FAIL err_set got perr=%0b required 1", perr);
        end
        wp = 5'd6;
        tick(2);
        checks++;
        if (perr !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got perr=%0b required 1", perr);
        end
        wp = 5'd2;
        clr = 1'b1;
        tick(1);
        checks++;
        if (perr !== 1'b1) begin
            failures++;
            $display("FAIL err_set_wins got perr=%0b required 1", perr);
        end
        wp = 5'd6;
        tick(1);
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got perr=%0b required 0", perr);
        end
        clr = 1'b0;
        tick(1);
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL err_stays_clear got perr=%0b required 0", perr);
        end
    endtask

    task automatic test_sync_valid();
        rst3 = 1'b1;
        tick(1);
        rst3 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            checks++;
            if (sv3 !== 1'b0) begin
                failures++;
                $display("FAIL sync_valid_early edge=%0d got %0b required 0", e, sv3);
            end
        end
        tick(1);
        checks++;
        if (sv3 !== 1'b1) begin
            failures++;
            $display("FAIL sync_valid_edge4 got %0b required 1", sv3);
        end
        for (int e = 0; e < 20; e++) begin
            tick(1);
            checks++;
            if (sv3 !== 1'b1) begin
                failures++;
                $display("FAIL sync_valid_hold edge=%0d got %0b required 1", e + 5, sv3);
            end
        end
        checks++;
        if (srp3 !== 5'b00110 || srp_bin3 !== 5'd4) begin
            failures++;
            $display("FAIL sync3_settled got srp=%b bin=%0d required 00110/4", srp3, srp_bin3);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_latency();
        test_full();
        test_wrap();
        test_error();
        test_sync_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_side_pointer_sync.md
# write_side_pointer_sync

Parametrised write-domain receiver for the async FIFO's gray-coded read pointer. It synchronises the pointer through a configurable N-flop chain and converts it to binary. It derives occupancy, full and almost-full against the local binary write pointer, and latches a sticky error if the pointers ever violate the FIFO invariant. It sits in the write clock domain between the read-pointer crossing and the write-side control logic.

## Interface
Parameters:
- ADDRESS_SIZE, 4, FIFO address bits; pointers are ADDRESS_SIZE+1 bits; DEPTH = 2^ADDRESS_SIZE
- SYNC_STAGES, 2, synchroniser flops, legal range 2..4
- ALMOST_FULL_MARGIN, 2, almost_full when used_count >= DEPTH - ALMOST_FULL_MARGIN; legal range 1..DEPTH-1

Ports:
- write_clk  in  1  write-domain clock, sole clock
- write_reset  in  1  asynchronous, active-high reset
- read_pointer  in  ADDRESS_SIZE+1  gray-coded read pointer, asynchronous to write_clk
- write_pointer_bin  in  ADDRESS_SIZE+1  local binary write pointer, write_clk domain
- error_clear  in  1  clears pointer_error
- synchronized_read_pointer  out  ADDRESS_SIZE+1  gray pointer, last synchroniser stage
- synchronized_read_pointer_bin  out  ADDRESS_SIZE+1  registered binary of the above
- used_count  out  ADDRESS_SIZE+1  FIFO occupancy seen by the writer
- full  out  1  used_count >= DEPTH
- almost_full  out  1  used_count >= DEPTH - ALMOST_FULL_MARGIN
- pointer_error  out  1  sticky invariant violation
- sync_valid  out  1  synchroniser pipeline flushed since reset

## Operation
- Synchroniser: stage[0] <= read_pointer; stage[i] <= stage[i-1]; synchronized_read_pointer = stage[SYNC_STAGES-1]. Only stage[0] samples the asynchronous input. No logic between stages.
- Gray to binary:
  - b[ADDRESS_SIZE] = g[ADDRESS_SIZE]
  - b[i] = b[i+1] ^ g[i]
  - Computed from the last stage and registered into synchronized_read_pointer_bin.
- used_count: combinational, write_pointer_bin - synchronized_read_pointer_bin, modulo 2^(ADDRESS_SIZE+1). The unsigned wrap is intentional.
- full and almost_full: combinational compares on used_count. This lets the writer see full in the same cycle its pointer advances.
- pointer_error:
  - Set on the edge after any cycle where used_count > DEPTH, meaning the read pointer has passed the write pointer or the writer has overrun.
  - Cleared on an edge where error_clear=1 and the set condition is false.
  - If set and clear occur together, set wins.
- sync_valid:
  - A saturating counter of 0..SYNC_STAGES+1, counting edges since reset release.
  - sync_valid=1 once the count reaches SYNC_STAGES+1; it then stays 1 until reset.
  - Outputs are defined before this point, but reflect reset zeros rather than the live pointer.
- Reset (asynchronous, any time, including mid-operation):
  - All stages, the binary register, the counter, pointer_error and sync_valid go to 0 immediately.
  - used_count/full/almost_full then follow write_pointer_bin - 0.

## Timing
- A read_pointer value stable across edge k appears on synchronized_read_pointer after edge k+SYNC_STAGES-1. It appears on synchronized_read_pointer_bin after edge k+SYNC_STAGES.
- Total crossing latency is SYNC_STAGES+1 write_clk edges. full/almost_full/used_count add zero cycles on top.
- A change on write_pointer_bin is reflected on used_count/full/almost_full in the same cycle.
- pointer_error has 1-cycle latency from the violating cycle.
- Full is pessimistic by the crossing latency, never optimistic.

## Test plan
- Reset mid-stream: drive read_pointer=5'b10001, run 5 edges, pulse write_reset between edges -> all stages, both synchronized pointers, pointer_error and sync_valid read 0 before the next edge.
- Latency (ADDRESS_SIZE=4, SYNC_STAGES=2): read_pointer 0 -> 5'b00001 before edge k -> synchronized_read_pointer=00001 after edge k+1; synchronized_read_pointer_bin=1 after edge k+2.
- Full/almost-full (margin 2, read pointer settled at 0):
  - write_pointer_bin=13 -> used 13, almost_full=0
  - write_pointer_bin=14 -> almost_full=1, full=0
  - write_pointer_bin=16 -> used 16, full=1
- Wrap-around: settled read gray 5'b10001 (bin 30), write_pointer_bin=3 -> used_count=5, full=0, pointer_error stays 0.
- Error sticky/clear, with settled read bin 4:
  - write_pointer_bin=2 -> used_count=30 -> pointer_error=1 next edge.
  - Restore write_pointer_bin=6 -> pointer_error stays 1.
  - error_clear=1 while the violation is reasserted -> stays 1.
  - error_clear=1 with no violation -> 0 next edge.
- sync_valid with SYNC_STAGES=3: release reset -> sync_valid=0 through edge 3, =1 after edge 4, stays 1 over 20 further edges.
